zeroriscy_instr_realigner: RTL
==============================

# zeroriscy_instr_realigner

Instruction realignment buffer between the instruction-fetch interface and `zeroriscy_compressed_decoder`. Buffers word-aligned 32-bit fetch words and presents one instruction per handshake, 16-bit (compressed) or 32-bit. A 32-bit instruction may start on a halfword boundary and straddle two fetch words. Each instruction is tagged with its byte address. Branches and jumps flush the buffer and may restart on a halfword-aligned target.

## Interface

Parameters:
- `DEPTH`, 3, number of 32-bit fetch-word entries (≥2).

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `clear_i`  in  1  synchronous flush, highest priority.
- `branch_addr_i`  in  32  restart byte address, sampled when `clear_i`=1; only bit 1 is used.
- `in_valid_i`  in  1  fetch word valid.
- `in_ready_o`  out  1  buffer can accept a word.
- `in_rdata_i`  in  32  fetch word.
- `in_addr_i`  in  32  fetch word address; bits [1:0] are ignored.
- `out_valid_o`  out  1  instruction valid.
- `out_ready_i`  in  1  decoder consumes the instruction.
- `out_rdata_o`  out  32  instruction; bits [31:16] are zero when the instruction is compressed.
- `out_addr_o`  out  32  instruction byte address.

## Operation

- **Storage**
  - FIFO of `DEPTH` entries {rdata, addr[31:2]} with occupancy `count`.
  - `hw_sel` (1 bit) selects the starting halfword inside the head entry.
- **Push:** `in_valid_i && in_ready_o && !clear_i`. `in_ready_o = (count < DEPTH)`.
- **Head H, next entry N.** An instruction is compressed when its low two bits are not 2'b11.
  - `hw_sel`=0, `H[1:0]`≠11: output `{16'h0, H[15:0]}`, valid if `count`≥1. On consume, `hw_sel`←1; no pop.
  - `hw_sel`=0, `H[1:0]`=11: output `H`, valid if `count`≥1. On consume, pop; `hw_sel` stays 0.
  - `hw_sel`=1, `H[17:16]`≠11: output `{16'h0, H[31:16]}`, valid if `count`≥1. On consume, pop; `hw_sel`←0.
  - `hw_sel`=1, `H[17:16]`=11 (straddle): output `{N[15:0], H[31:16]}`, valid only if `count`≥2. On consume, pop H; `hw_sel` stays 1.
- **Output address:** `out_addr_o = {H.addr[31:2], hw_sel, 1'b0}`.
- **Invalid output:** when `out_valid_o`=0, `out_rdata_o` and `out_addr_o` are 0.
- **Consume:** `out_valid_o && out_ready_i && !clear_i`. Push and pop in the same cycle are allowed; `count` updates by +1, −1 or 0 accordingly.
- **Clear:** `count`←0 and `hw_sel`←`branch_addr_i[1]`. Push and consume in the same cycle are dropped. The fetch unit then supplies the word containing the target; a lower halfword is skipped via `hw_sel`.
- **Not performed here:** no illegal-instruction or address-continuity checking. Decoding belongs to `zeroriscy_compressed_decoder`.

## Timing

- **Reset values:** `count`=0, `hw_sel`=0. Therefore `out_valid_o`=0, `out_rdata_o`=0, `out_addr_o`=0, `in_ready_o`=1.
- **Latency:** a word accepted in cycle t makes an instruction visible in cycle t+1; there is no input-to-output bypass.
- **Straddle:** visible in the cycle after the second word is accepted.
- **Output path:** all outputs are combinational from registers only.
  - No combinational path from `in_*` to `out_*`.
  - No combinational path from `out_ready_i` to `in_ready_o`.
- **Valid-hold rule:** once `out_valid_o`=1, `out_rdata_o`/`out_addr_o` hold until consumed or cleared. A push never alters the presented instruction.
- **Full:** `in_ready_o`=0 while `count`=`DEPTH`, even if a consume happens in the same cycle. It rises in the cycle after the pop.
- **Reset mid-operation:** asynchronous return to the reset values; buffered words are lost.
- **Clear during a stalled straddle:** the straddle is discarded; `out_valid_o`=0 in the next cycle.

## Test plan

- **Reset:** assert `rst_n`=0 mid-stream → `out_valid_o`=0, `out_rdata_o`=0, `out_addr_o`=0, `in_ready_o`=1 immediately, without waiting for a clock edge.
- **Aligned 32-bit stream:** push 0x00000013@0x100, 0x00100093@0x104 with `out_ready_i`=1 → outputs 0x00000013@0x100 then 0x00100093@0x104, each one cycle after its push.
- **Compressed pair:** push 0x00050001@0x200 → outputs 0x00000001@0x200 then 0x00000005@0x202, followed by a single pop.
- **Straddle:**
  - Push 0x00130001@0x300 → 0x00000001@0x300, then `out_valid_o`=0 until the next word arrives.
  - Push 0x00090000@0x304 → 0x00000013@0x302 the next cycle, then 0x00000009@0x306.
- **Clear to halfword target:**
  - With 2 words buffered, pulse `clear_i` with `branch_addr_i`=0x402 while also pushing → next cycle `count`=0 and `out_valid_o`=0; the same-cycle push is dropped.
  - Push 0x00050011@0x400 → 0x00000005@0x402; the lower halfword is skipped.
- **Backpressure and full:**
  - `out_ready_i`=0, push 3 words → `in_ready_o`=0 after the third, and the presented instruction is stable.
  - Raise `out_ready_i` for one consume of a 32-bit word → `in_ready_o`=1 the following cycle; the 4th word is accepted and ordering is preserved.

Source files
------------

// File: rtl/zeroriscy_instr_realigner.sv
// -----------------------------------------------------------------------------
// zeroriscy_instr_realigner
//
// Realigns the word-aligned 32-bit fetch stream into one instruction per
// handshake for zeroriscy_compressed_decoder. Compressed instructions (low two
// bits != 2'b11) are presented zero-extended. A 32-bit instruction that begins
// in the upper halfword of one fetch word is stitched together with the lower
// halfword of the following word. Every instruction carries its byte address.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   clear_i          synchronous flush (wins over push and consume)
//   branch_addr_i    restart address; bit 1 selects the starting halfword
//   in_valid_i       fetch word valid
//   in_ready_o       buffer has a free entry
//   in_rdata_i       fetch word
//   in_addr_i        fetch word address ([1:0] ignored)
//   out_valid_o      instruction valid
//   out_ready_i      decoder consumes the instruction
//   out_rdata_o      instruction (upper half zero when compressed)
//   out_addr_o       instruction byte address
//
// All outputs are decoded from registers only: no in_* -> out_* path and no
// out_ready_i -> in_ready_o path.
// -----------------------------------------------------------------------------
module zeroriscy_instr_realigner #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic [31:0] branch_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_rdata_i,
  input  logic [31:0] in_addr_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  // storage
  logic [31:0]      mem_rdata_q [DEPTH];
  logic [31:0]      mem_rdata_d [DEPTH];
  logic [29:0]      mem_addr_q  [DEPTH];
  logic [29:0]      mem_addr_d  [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             hw_sel_q, hw_sel_d;

  // head / next view
  logic [PTR_W-1:0] nx_ptr;
  logic [31:0]      head_rdata;
  logic [29:0]      head_addr;
  logic [31:0]      next_rdata;
  logic             has_one;
  logic             has_two;

  // instruction selection
  logic        instr_valid;
  logic [31:0] instr_rdata;
  logic        instr_pops;
  logic        instr_hw_sel;

  logic push;
  logic consume;
  logic do_pop;

  // Bits of the address inputs that carry no information for this block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{in_addr_i[1:0], branch_addr_i[31:2], branch_addr_i[0]};

  function automatic logic [PTR_W-1:0] ptr_incr(input logic [PTR_W-1:0] p);
    ptr_incr = (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign nx_ptr     = ptr_incr(rd_ptr_q);
  assign head_rdata = mem_rdata_q[rd_ptr_q];
  assign head_addr  = mem_addr_q[rd_ptr_q];
  assign next_rdata = mem_rdata_q[nx_ptr];
  assign has_one    = (count_q != '0);
  assign has_two    = (count_q >= CNT_TWO);

  // Pick the instruction starting at the selected halfword of the head entry.
  // instr_hw_sel is the halfword select that follows a consume.
  always_comb begin
    instr_valid  = 1'b0;
    instr_rdata  = '0;
    instr_pops   = 1'b0;
    instr_hw_sel = hw_sel_q;
    if (!hw_sel_q) begin
      if (head_rdata[1:0] != 2'b11) begin
        instr_valid  = has_one;
        instr_rdata  = {16'h0000, head_rdata[15:0]};
        instr_pops   = 1'b0;
        instr_hw_sel = 1'b1;
      end else begin
        instr_valid  = has_one;
        instr_rdata  = head_rdata;
        instr_pops   = 1'b1;
        instr_hw_sel = 1'b0;
      end
    end else begin
      if (head_rdata[17:16] != 2'b11) begin
        instr_valid  = has_one;
        instr_rdata  = {16'h0000, head_rdata[31:16]};
        instr_pops   = 1'b1;
        instr_hw_sel = 1'b0;
      end else begin
        // Straddle: the upper half lives in the next entry, which stays
        // buffered with its upper halfword still pending.
        instr_valid  = has_two;
        instr_rdata  = {next_rdata[15:0], head_rdata[31:16]};
        instr_pops   = 1'b1;
        instr_hw_sel = 1'b1;
      end
    end
  end

  assign out_valid_o = instr_valid;
  assign out_rdata_o = instr_valid ? instr_rdata : 32'h0;
  assign out_addr_o  = instr_valid ? {head_addr, hw_sel_q, 1'b0} : 32'h0;
  assign in_ready_o  = (count_q < CNT_FULL);

  assign push    = in_valid_i && in_ready_o && !clear_i;
  assign consume = instr_valid && out_ready_i && !clear_i;
  assign do_pop  = consume && instr_pops;

  always_comb begin
    mem_rdata_d = mem_rdata_q;
    mem_addr_d  = mem_addr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    hw_sel_d    = hw_sel_q;

    if (push) begin
      mem_rdata_d[wr_ptr_q] = in_rdata_i;
      mem_addr_d[wr_ptr_q]  = in_addr_i[31:2];
      wr_ptr_d              = ptr_incr(wr_ptr_q);
    end

    if (do_pop) begin
      rd_ptr_d = nx_ptr;
    end

    if (consume) begin
      hw_sel_d = instr_hw_sel;
    end

    case ({push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Flush; the stale entries are simply abandoned.
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      hw_sel_d = branch_addr_i[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_rdata_q[i] <= '0;
        mem_addr_q[i]  <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      hw_sel_q <= 1'b0;
    end else begin
      mem_rdata_q <= mem_rdata_d;
      mem_addr_q  <= mem_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      hw_sel_q    <= hw_sel_d;
    end
  end

endmodule
